// File: rtl/board_ram_responder_pkg.sv
// Shared types and defaults for the board RAM responder: FSM states,
// parameter defaults, read-return beat and address legality check.
package board_ram_responder_pkg;

  localparam int unsigned DATA_W           = 32;
  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned STALL_CNT_W      = 4;
  localparam int unsigned DEF_DEPTH_WORDS  = 1024;
  localparam int unsigned DEF_READ_LATENCY = 2;
  localparam int unsigned DEF_STALL_CYCLES = 0;

  localparam logic [DATA_W-1:0] ERR_READ_VALUE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_READY = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } rd_beat_t;

  // Word-aligned and inside the stored word range.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr,
                                   input int unsigned       depth);
    return (addr[1:0] == 2'b00) &&
           ({2'b00, addr[ADDR_W-1:2]} < ADDR_W'(depth));
  endfunction

endpackage

// File: rtl/board_ram_responder_rd_latency_pipe.sv
// Fixed-depth valid+data shift register that delays read returns.
// Data is forced to zero on empty stages so the output is 0 when not valid.
module board_ram_responder_rd_latency_pipe
  import board_ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_READ_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  rd_beat_t r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0].valid <= i_valid;
      r_stage[0].data  <= i_valid ? i_data : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_valid = r_stage[DEPTH-1].valid;
  assign o_data  = r_stage[DEPTH-1].data;

endmodule

// File: rtl/board_ram_responder.sv
// Avalon-MM style word RAM slave: clears itself after reset, optionally
// stalls each request, and returns reads after a fixed pipeline latency.
module board_ram_responder
  import board_ram_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = DEF_DEPTH_WORDS,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
  parameter int unsigned STALL_CYCLES = DEF_STALL_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [DATA_W-1:0] slave_writedata,
  output logic              slave_waitrequest,
  output logic [DATA_W-1:0] slave_readdata,
  output logic              slave_readdatavalid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       r_clr_idx;
  logic [IDX_W-1:0]       w_clr_idx_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic [STALL_CNT_W-1:0] w_stall_cnt_nxt;
  logic                   r_waitrequest;
  logic                   r_busy;
  logic                   r_err;

  logic                   w_req;
  logic                   w_addr_ok;
  logic                   w_mem_we;
  logic [IDX_W-1:0]       w_mem_addr;
  logic [DATA_W-1:0]      w_mem_wdata;
  logic [DATA_W-1:0]      w_rd_data;
  logic                   w_rd_issue;
  logic                   w_err_set;

  logic [DATA_W-1:0]      r_mem [DEPTH_WORDS];

  assign w_req     = slave_read | slave_write;
  assign w_addr_ok = addr_ok(slave_address, DEPTH_WORDS);

  // State, clear index and stall counter; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_CLEAR;
      r_clr_idx     <= '0;
      r_stall_cnt   <= STALL_CNT_W'(STALL_CYCLES);
      r_waitrequest <= 1'b1;
      r_busy        <= 1'b1;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_clr_idx     <= w_clr_idx_nxt;
      r_stall_cnt   <= w_stall_cnt_nxt;
      r_waitrequest <= (w_state_nxt != ST_READY);
      r_busy        <= (w_state_nxt == ST_CLEAR);
      r_err         <= r_err | w_err_set;
    end
  end

  // Next-state logic and the single RAM port steering.
  always_comb begin
    w_state_nxt     = r_state;
    w_clr_idx_nxt   = r_clr_idx;
    w_stall_cnt_nxt = r_stall_cnt;
    w_mem_we        = 1'b0;
    w_mem_addr      = slave_address[IDX_W+1:2];
    w_mem_wdata     = slave_writedata;
    w_rd_issue      = 1'b0;
    w_err_set       = 1'b0;

    case (r_state)
      ST_CLEAR: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_clr_idx;
        w_mem_wdata = '0;
        if (r_clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
          w_clr_idx_nxt   = '0;
          w_stall_cnt_nxt = STALL_CNT_W'(STALL_CYCLES);
          w_state_nxt     = (STALL_CYCLES == 0) ? ST_READY : ST_STALL;
        end else begin
          w_clr_idx_nxt = r_clr_idx + IDX_W'(1);
        end
      end

      ST_READY: begin
        if (w_req) begin
          // Simultaneous read+write keeps the write and drops the read.
          w_mem_we   = slave_write & w_addr_ok;
          w_rd_issue = slave_read & ~slave_write;
          w_err_set  = ~w_addr_ok | (slave_read & slave_write);
          if (STALL_CYCLES != 0) begin
            w_state_nxt     = ST_STALL;
            w_stall_cnt_nxt = STALL_CNT_W'(STALL_CYCLES);
          end
        end
      end

      ST_STALL: begin
        // Only cycles with a pending request consume stall count.
        if (w_req) begin
          if (r_stall_cnt <= STALL_CNT_W'(1)) begin
            w_state_nxt     = ST_READY;
            w_stall_cnt_nxt = '0;
          end else begin
            w_stall_cnt_nxt = r_stall_cnt - STALL_CNT_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // Single-port storage; no writes land while reset is held.
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  assign w_rd_data = w_addr_ok ? r_mem[w_mem_addr] : ERR_READ_VALUE;

  board_ram_responder_rd_latency_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_rd_latency_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_rd_issue),
    .i_data  (w_rd_data),
    .o_valid (slave_readdatavalid),
    .o_data  (slave_readdata)
  );

  assign slave_waitrequest = r_waitrequest;
  assign busy              = r_busy;
  assign err               = r_err;

endmodule
